// File: rtl/rv32_pkg.sv
// Shared types for the memory-stage data port. These are the owner IDs that
// go into the ID FIFO and the state encoding of the data-cache port arbiter.
package rv32_pkg;

  typedef enum logic {
    DMEM_PTW = 1'b0,
    DMEM_LSU = 1'b1
  } dmem_owner_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } dmem_arb_state_e;

endpackage

// File: rtl/dmem_id_fifo.sv
// In-order FIFO of 1-bit owner IDs, one entry per outstanding cache access.
// A push is allowed while full when a pop happens in the same cycle.
module dmem_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  assign full_o    = (r_count == CNT_W'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign head_o    = r_mem[r_rd_ptr];
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_id_i;
        r_wr_ptr        <= nextPtr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= nextPtr(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-cache request port between the page-table walker and
// the load/store unit, and routes in-order cache responses back to their issuer.
module dmem_port_arbiter
  import rv32_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_OUT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ptw_req_i,
  input  logic [ADDR_W-1:0]   ptw_addr_i,
  output logic                ptw_gnt_o,
  output logic                ptw_rsp_valid_o,
  output logic [DATA_W-1:0]   ptw_rsp_data_o,
  output logic                ptw_rsp_err_o,
  input  logic                lsu_req_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic                lsu_we_i,
  input  logic [DATA_W/8-1:0] lsu_be_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rsp_valid_o,
  output logic [DATA_W-1:0]   lsu_rsp_data_o,
  output logic                lsu_rsp_err_o,
  output logic                dc_req_o,
  output logic [ADDR_W-1:0]   dc_addr_o,
  output logic                dc_we_o,
  output logic [DATA_W/8-1:0] dc_be_o,
  output logic [DATA_W-1:0]   dc_wdata_o,
  input  logic                dc_gnt_i,
  input  logic                dc_rsp_valid_i,
  input  logic [DATA_W-1:0]   dc_rsp_data_i,
  input  logic                dc_rsp_err_i,
  output logic                busy_o,
  output logic                protocol_err_o
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  dmem_arb_state_e r_state;
  dmem_owner_e     r_owner;
  logic [CNT_W-1:0] r_starve_cnt;
  logic            r_protocol_err;

  dmem_owner_e w_owner;
  logic        w_active;
  logic        w_starved;
  logic        w_room;
  logic        w_accept;
  logic        w_pop_valid;
  logic        w_full;
  logic        w_empty;
  logic        w_head;

  assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIM));

  // A locked owner keeps the port; otherwise PTW wins unless a waiting LSU is starved.
  always_comb begin
    w_owner  = DMEM_PTW;
    w_active = 1'b0;
    if (r_state == ARB_LOCK) begin
      w_owner  = r_owner;
      w_active = 1'b1;
    end else if (ptw_req_i && !(w_starved && lsu_req_i)) begin
      w_owner  = DMEM_PTW;
      w_active = 1'b1;
    end else if (lsu_req_i) begin
      w_owner  = DMEM_LSU;
      w_active = 1'b1;
    end
    if (rst_i) begin
      w_active = 1'b0;
    end
  end

  always_comb begin
    dc_addr_o  = '0;
    dc_we_o    = 1'b0;
    dc_be_o    = '0;
    dc_wdata_o = '0;
    if (w_active) begin
      if (w_owner == DMEM_PTW) begin
        dc_addr_o = ptw_addr_i;
        dc_be_o   = '1;
      end else begin
        dc_addr_o  = lsu_addr_i;
        dc_we_o    = lsu_we_i;
        dc_be_o    = lsu_be_i;
        dc_wdata_o = lsu_wdata_i;
      end
    end
  end

  assign w_pop_valid = dc_rsp_valid_i && !w_empty;
  assign w_room      = !w_full || w_pop_valid;
  assign dc_req_o    = w_active && w_room;
  assign w_accept    = dc_req_o && dc_gnt_i;
  assign ptw_gnt_o   = w_accept && (w_owner == DMEM_PTW);
  assign lsu_gnt_o   = w_accept && (w_owner == DMEM_LSU);

  assign ptw_rsp_valid_o = w_pop_valid && (w_head == DMEM_PTW);
  assign lsu_rsp_valid_o = w_pop_valid && (w_head == DMEM_LSU);
  assign ptw_rsp_data_o  = ptw_rsp_valid_o ? dc_rsp_data_i : '0;
  assign lsu_rsp_data_o  = lsu_rsp_valid_o ? dc_rsp_data_i : '0;
  assign ptw_rsp_err_o   = ptw_rsp_valid_o && dc_rsp_err_i;
  assign lsu_rsp_err_o   = lsu_rsp_valid_o && dc_rsp_err_i;

  assign busy_o         = !w_empty || (r_state == ARB_LOCK);
  assign protocol_err_o = r_protocol_err;

  dmem_id_fifo #(
    .DEPTH(MAX_OUT)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (w_accept),
    .push_id_i(w_owner),
    .pop_i    (dc_rsp_valid_i),
    .head_o   (w_head),
    .full_o   (w_full),
    .empty_o  (w_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ARB_IDLE;
      r_owner <= DMEM_PTW;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (dc_req_o && !dc_gnt_i) begin
            r_state <= ARB_LOCK;
            r_owner <= w_owner;
          end
        end
        ARB_LOCK: begin
          if (w_accept) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (lsu_gnt_o) begin
      r_starve_cnt <= '0;
    end else if (lsu_req_i && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  // A response with nothing outstanding means the cache and arbiter lost sync.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_protocol_err <= 1'b0;
    end else if (dc_rsp_valid_i && w_empty) begin
      r_protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a per-cycle vector table with
// hand-computed expectations plus a hand-written reset-during-LOCK sequence.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        ptwReq;
  logic [31:0] ptwAddr;
  logic        ptwGnt;
  logic        ptwRspValid;
  logic [31:0] ptwRspData;
  logic        ptwRspErr;
  logic        lsuReq;
  logic [31:0] lsuAddr;
  logic        lsuWe;
  logic [3:0]  lsuBe;
  logic [31:0] lsuWdata;
  logic        lsuGnt;
  logic        lsuRspValid;
  logic [31:0] lsuRspData;
  logic        lsuRspErr;
  logic        dcReq;
  logic [31:0] dcAddr;
  logic        dcWe;
  logic [3:0]  dcBe;
  logic [31:0] dcWdata;
  logic        dcGnt;
  logic        dcRspValid;
  logic [31:0] dcRspData;
  logic        dcRspErr;
  logic        busy;
  logic        protocolErr;

  int testsRun  = 0;
  int testsFail = 0;

  typedef struct {
    logic        ptwReq;
    logic [31:0] ptwAddr;
    logic        lsuReq;
    logic [31:0] lsuAddr;
    logic        lsuWe;
    logic [3:0]  lsuBe;
    logic [31:0] lsuWdata;
    logic        dcGnt;
    logic        rspValid;
    logic [31:0] rspData;
    logic        rspErr;
    logic        eDcReq;
    logic [31:0] eDcAddr;
    logic        eDcWe;
    logic [3:0]  eDcBe;
    logic [31:0] eDcWdata;
    logic        ePtwGnt;
    logic        eLsuGnt;
    logic        ePtwRspV;
    logic        eLsuRspV;
    logic        eBusy;
    logic        ePerr;
  } vec_t;

  vec_t vecs[$];

  dmem_port_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ptw_req_i      (ptwReq),
    .ptw_addr_i     (ptwAddr),
    .ptw_gnt_o      (ptwGnt),
    .ptw_rsp_valid_o(ptwRspValid),
    .ptw_rsp_data_o (ptwRspData),
    .ptw_rsp_err_o  (ptwRspErr),
    .lsu_req_i      (lsuReq),
    .lsu_addr_i     (lsuAddr),
    .lsu_we_i       (lsuWe),
    .lsu_be_i       (lsuBe),
    .lsu_wdata_i    (lsuWdata),
    .lsu_gnt_o      (lsuGnt),
    .lsu_rsp_valid_o(lsuRspValid),
    .lsu_rsp_data_o (lsuRspData),
    .lsu_rsp_err_o  (lsuRspErr),
    .dc_req_o       (dcReq),
    .dc_addr_o      (dcAddr),
    .dc_we_o        (dcWe),
    .dc_be_o        (dcBe),
    .dc_wdata_o     (dcWdata),
    .dc_gnt_i       (dcGnt),
    .dc_rsp_valid_i (dcRspValid),
    .dc_rsp_data_i  (dcRspData),
    .dc_rsp_err_i   (dcRspErr),
    .busy_o         (busy),
    .protocol_err_o (protocolErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ptwReq     = v.ptwReq;
    ptwAddr    = v.ptwAddr;
    lsuReq     = v.lsuReq;
    lsuAddr    = v.lsuAddr;
    lsuWe      = v.lsuWe;
    lsuBe      = v.lsuBe;
    lsuWdata   = v.lsuWdata;
    dcGnt      = v.dcGnt;
    dcRspValid = v.rspValid;
    dcRspData  = v.rspData;
    dcRspErr   = v.rspErr;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d ", idx);
    checkOutput({p, "dc_req"},        32'(dcReq),        32'(v.eDcReq));
    checkOutput({p, "dc_addr"},       dcAddr,            v.eDcAddr);
    checkOutput({p, "dc_we"},         32'(dcWe),         32'(v.eDcWe));
    checkOutput({p, "dc_be"},         32'(dcBe),         32'(v.eDcBe));
    checkOutput({p, "dc_wdata"},      dcWdata,           v.eDcWdata);
    checkOutput({p, "ptw_gnt"},       32'(ptwGnt),       32'(v.ePtwGnt));
    checkOutput({p, "lsu_gnt"},       32'(lsuGnt),       32'(v.eLsuGnt));
    checkOutput({p, "ptw_rsp_valid"}, 32'(ptwRspValid),  32'(v.ePtwRspV));
    checkOutput({p, "lsu_rsp_valid"}, 32'(lsuRspValid),  32'(v.eLsuRspV));
    checkOutput({p, "ptw_rsp_data"},  ptwRspData,        v.ePtwRspV ? v.rspData : 32'h0);
    checkOutput({p, "lsu_rsp_data"},  lsuRspData,        v.eLsuRspV ? v.rspData : 32'h0);
    checkOutput({p, "ptw_rsp_err"},   32'(ptwRspErr),    32'(v.ePtwRspV & v.rspErr));
    checkOutput({p, "lsu_rsp_err"},   32'(lsuRspErr),    32'(v.eLsuRspV & v.rspErr));
    checkOutput({p, "busy"},          32'(busy),         32'(v.eBusy));
    checkOutput({p, "protocol_err"},  32'(protocolErr),  32'(v.ePerr));
  endtask

  task automatic checkAllZero(input string p);
    checkOutput({p, " dc_req"},        32'(dcReq),       32'h0);
    checkOutput({p, " dc_addr"},       dcAddr,           32'h0);
    checkOutput({p, " dc_we"},         32'(dcWe),        32'h0);
    checkOutput({p, " dc_be"},         32'(dcBe),        32'h0);
    checkOutput({p, " dc_wdata"},      dcWdata,          32'h0);
    checkOutput({p, " ptw_gnt"},       32'(ptwGnt),      32'h0);
    checkOutput({p, " lsu_gnt"},       32'(lsuGnt),      32'h0);
    checkOutput({p, " ptw_rsp_valid"}, 32'(ptwRspValid), 32'h0);
    checkOutput({p, " lsu_rsp_valid"}, 32'(lsuRspValid), 32'h0);
    checkOutput({p, " busy"},          32'(busy),        32'h0);
    checkOutput({p, " protocol_err"},  32'(protocolErr), 32'h0);
  endtask

  // Each entry is one clock cycle; fields follow the vec_t declaration order.
  initial begin
    // Single LSU store then its response two cycles later
    vecs.push_back('{1'b0,32'h0,   1'b1,32'h1000,1'b1,4'hF,32'hDEADBEEF, 1'b1, 1'b0,32'h0,1'b0,        1'b1,32'h1000,1'b1,4'hF,32'hDEADBEEF, 1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b0,32'h0,1'b0,        1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b1,32'h12345678,1'b0, 1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b0,32'h0,1'b0,        1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0});
    // PTW and LSU together: PTW first, then LSU; responses routed in order
    vecs.push_back('{1'b1,32'h2000,1'b1,32'h3000,1'b0,4'h3,32'h0,        1'b1, 1'b0,32'h0,1'b0,        1'b1,32'h2000,1'b0,4'hF,32'h0,        1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b1,32'h3000,1'b0,4'h3,32'h0,        1'b1, 1'b0,32'h0,1'b0,        1'b1,32'h3000,1'b0,4'h3,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b1,32'hAAAA0001,1'b1, 1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b1,32'hBBBB0002,1'b0, 1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b0,32'h0,1'b0,        1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0});
    // LSU locked while dc_gnt is low; PTW arriving later must not preempt
    vecs.push_back('{1'b0,32'h0,   1'b1,32'h4000,1'b0,4'hF,32'h0,        1'b0, 1'b0,32'h0,1'b0,        1'b1,32'h4000,1'b0,4'hF,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b1,32'h4000,1'b0,4'hF,32'h0,        1'b0, 1'b0,32'h0,1'b0,        1'b1,32'h4000,1'b0,4'hF,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b1,32'h5000,1'b1,32'h4000,1'b0,4'hF,32'h0,        1'b0, 1'b0,32'h0,1'b0,        1'b1,32'h4000,1'b0,4'hF,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b1,32'h5000,1'b1,32'h4000,1'b0,4'hF,32'h0,        1'b1, 1'b0,32'h0,1'b0,        1'b1,32'h4000,1'b0,4'hF,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b1,32'h5000,1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b1, 1'b0,32'h0,1'b0,        1'b1,32'h5000,1'b0,4'hF,32'h0,        1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b1,32'h11,1'b0,       1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b1,32'h22,1'b0,       1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b0,32'h0,1'b0,        1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0});
    // PTW every cycle: LSU waits four cycles, then wins; counter clears after
    vecs.push_back('{1'b1,32'h6000,1'b1,32'h7000,1'b1,4'hC,32'hCAFE0000, 1'b1, 1'b0,32'h0,1'b0,        1'b1,32'h6000,1'b0,4'hF,32'h0,        1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0});
    vecs.push_back('{1'b1,32'h6000,1'b1,32'h7000,1'b1,4'hC,32'hCAFE0000, 1'b1, 1'b1,32'h30,1'b0,       1'b1,32'h6000,1'b0,4'hF,32'h0,        1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b1,32'h6000,1'b1,32'h7000,1'b1,4'hC,32'hCAFE0000, 1'b1, 1'b1,32'h31,1'b0,       1'b1,32'h6000,1'b0,4'hF,32'h0,        1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b1,32'h6000,1'b1,32'h7000,1'b1,4'hC,32'hCAFE0000, 1'b1, 1'b1,32'h32,1'b0,       1'b1,32'h6000,1'b0,4'hF,32'h0,        1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b1,32'h6000,1'b1,32'h7000,1'b1,4'hC,32'hCAFE0000, 1'b1, 1'b1,32'h33,1'b0,       1'b1,32'h7000,1'b1,4'hC,32'hCAFE0000, 1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b1,32'h6000,1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b1, 1'b1,32'h34,1'b1,       1'b1,32'h6000,1'b0,4'hF,32'h0,        1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0});
    vecs.push_back('{1'b1,32'h6000,1'b1,32'h7000,1'b1,4'hC,32'hCAFE0000, 1'b1, 1'b1,32'h35,1'b0,       1'b1,32'h6000,1'b0,4'hF,32'h0,        1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b1,32'h7000,1'b1,4'hC,32'hCAFE0000, 1'b1, 1'b1,32'h36,1'b0,       1'b1,32'h7000,1'b1,4'hC,32'hCAFE0000, 1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b1,32'h37,1'b0,       1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b0,32'h0,1'b0,        1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0});
    // FIFO full: third request blocked, allowed once a response pops an entry
    vecs.push_back('{1'b0,32'h0,   1'b1,32'h8000,1'b0,4'hF,32'h0,        1'b1, 1'b0,32'h0,1'b0,        1'b1,32'h8000,1'b0,4'hF,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b1,32'h8004,1'b0,4'hF,32'h0,        1'b1, 1'b0,32'h0,1'b0,        1'b1,32'h8004,1'b0,4'hF,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b1,32'h8008,1'b0,4'hF,32'h0,        1'b1, 1'b0,32'h0,1'b0,        1'b0,32'h8008,1'b0,4'hF,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b1,32'h8008,1'b0,4'hF,32'h0,        1'b1, 1'b1,32'h44,1'b0,       1'b1,32'h8008,1'b0,4'hF,32'h0,        1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b1,32'h800C,1'b0,4'hF,32'h0,        1'b1, 1'b0,32'h0,1'b0,        1'b0,32'h800C,1'b0,4'hF,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b1,32'h800C,1'b0,4'hF,32'h0,        1'b1, 1'b1,32'h45,1'b0,       1'b1,32'h800C,1'b0,4'hF,32'h0,        1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b1,32'h46,1'b0,       1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b1,32'h47,1'b0,       1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b0,32'h0,1'b0,        1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0});
    // Response with nothing outstanding: dropped, sticky protocol error
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b1,32'h55,1'b1,       1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b0,32'h0,1'b0,        1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1});
    vecs.push_back('{1'b0,32'h0,   1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0, 1'b0,32'h0,1'b0,        1'b0,32'h0,   1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1});

    rst        = 1'b1;
    ptwReq     = 1'b0;
    ptwAddr    = 32'h0;
    lsuReq     = 1'b0;
    lsuAddr    = 32'h0;
    lsuWe      = 1'b0;
    lsuBe      = 4'h0;
    lsuWdata   = 32'h0;
    dcGnt      = 1'b0;
    dcRspValid = 1'b0;
    dcRspData  = 32'h0;
    dcRspErr   = 1'b0;

    #2;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
    end

    // Reset while an LSU request is locked waiting for dc_gnt
    @(negedge clk);
    ptwReq = 1'b0;  dcRspValid = 1'b0;  dcRspErr = 1'b0;  dcRspData = 32'h0;
    lsuReq = 1'b1;  lsuAddr = 32'h9000;  lsuWe = 1'b0;  lsuBe = 4'hF;  lsuWdata = 32'h0;
    dcGnt  = 1'b0;
    #1;
    checkOutput("lock dc_req", 32'(dcReq), 32'h1);
    @(negedge clk);
    #1;
    checkOutput("lock busy", 32'(busy), 32'h1);
    checkOutput("lock dc_addr", dcAddr, 32'h9000);
    rst = 1'b1;
    #1;
    checkAllZero("mid-lock reset");
    @(negedge clk);
    #1;
    checkAllZero("held reset");
    @(negedge clk);
    rst   = 1'b0;
    dcGnt = 1'b1;
    #1;
    checkOutput("post-reset lsu_gnt", 32'(lsuGnt), 32'h1);
    checkOutput("post-reset dc_req", 32'(dcReq), 32'h1);
    checkOutput("post-reset dc_addr", dcAddr, 32'h9000);
    checkOutput("post-reset busy", 32'(busy), 32'h0);
    @(negedge clk);
    lsuReq = 1'b0;
    dcGnt  = 1'b0;
    #1;
    checkOutput("post-reset outstanding busy", 32'(busy), 32'h1);
    checkOutput("post-reset idle dc_req", 32'(dcReq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
